// File: rtl/crc_scan_fsm.sv
// Pipelined CRC address sequencer: one memory read per cycle over a configurable window.
// Optional cancel support is compiled in with the CRC_SCAN_ABORT_EN macro.
module crc_scan_fsm #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic              crc_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              crc_init,
  output logic              crc_en,
  output logic              crc_rdy,
  output logic              busy
`ifdef CRC_SCAN_ABORT_EN
  ,
  input  logic              abort,
  output logic              crc_aborted
`endif
);

  // state   | meaning
  // IDLE    | waiting for crc_start
  // INIT    | crc_init pulse, clears CRC register
  // FETCH   | one read per cycle until the window is exhausted
  // DRAIN   | RD_LAT cycles for the last read data to return
  // DONE    | crc_rdy pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;
  localparam logic [ADDR_W:0]   REM_ONE    = 1;
  localparam logic [ADDR_W:0]   REM_FULL   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   remaining;
  logic [2:0]        drain_cnt;
  logic [RD_LAT-1:0] en_pipe;
  logic              abort_hit;

`ifdef CRC_SCAN_ABORT_EN
  assign abort_hit = abort &&
                     ((state == S_INIT) || (state == S_FETCH) || (state == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (crc_start) state_next = S_INIT;
      S_INIT:  state_next = S_FETCH;
      S_FETCH: if (remaining == REM_ONE) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == 3'd0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort never applies in IDLE, so a simultaneous start still wins there.
    if (abort_hit) state_next = S_IDLE;
  end

  assign mem_rd_en = (state == S_FETCH);
  assign crc_init  = (state == S_INIT);
  assign crc_rdy   = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign crc_en    = en_pipe[RD_LAT-1];

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      remaining <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (crc_start) begin
            mem_addr  <= start_addr;
            remaining <= (word_count == '0) ? REM_FULL : {1'b0, word_count};
          end
        end
        S_FETCH: begin
          mem_addr  <= mem_addr + ADDR_ONE;
          remaining <= remaining - REM_ONE;
          drain_cnt <= DRAIN_LAST;
        end
        S_DRAIN: begin
          if (drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Read-strobe delay line matching the memory latency.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      en_pipe <= '0;
    end else if (abort_hit) begin
      en_pipe <= '0;
    end else begin
      en_pipe[0] <= mem_rd_en;
      for (int i = 1; i < RD_LAT; i++) en_pipe[i] <= en_pipe[i-1];
    end
  end

`ifdef CRC_SCAN_ABORT_EN
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      crc_aborted <= 1'b0;
    end else begin
      crc_aborted <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_crc_scan_fsm.sv
// Scoreboard bench for crc_scan_fsm (ADDR_W=10, RD_LAT=2): per-cycle expectations
// are queued at start and popped against the DUT outputs each cycle.
module tb_crc_scan_fsm;
  localparam int AW = 10;
  localparam int L  = 2;

  logic          clk50m = 1'b0;
  logic          rst = 1'b1;
  logic          crc_start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, crc_init, crc_en, crc_rdy, busy;
  logic          abort = 1'b0;
`ifdef CRC_SCAN_ABORT_EN
  logic          crc_aborted;
`endif

  int total = 0;
  int bad = 0;
  int en_count = 0;

  typedef struct {
    logic [4:0]    ctl;      // {init, rd_en, crc_en, rdy, busy}
    logic [AW-1:0] addr;
    logic          chk_addr;
    logic          abt;
  } exp_t;

  exp_t sb[$];

  crc_scan_fsm #(.ADDR_W(AW), .RD_LAT(L)) dut (
    .clk50m(clk50m), .rst(rst), .crc_start(crc_start),
    .start_addr(start_addr), .word_count(word_count),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .crc_init(crc_init),
    .crc_en(crc_en), .crc_rdy(crc_rdy), .busy(busy)
`ifdef CRC_SCAN_ABORT_EN
    , .abort(abort), .crc_aborted(crc_aborted)
`endif
  );

  always #10 clk50m = ~clk50m;

  always @(posedge clk50m) if (crc_en === 1'b1) en_count++;

  // Runs one scan from the start edge; pokes restart attempts, reset or abort at given cycles.
  task automatic run_scan(input int sa, input int wc, input int poke_a, input int poke_b,
                          input int rst_at, input int abort_at);
    int n, kmax;
    exp_t e;
    logic [4:0] got;
    n = (wc == 0) ? 1024 : wc;
    kmax = n + 4 + L;
    @(negedge clk50m);
    crc_start  = 1'b1;
    start_addr = AW'(sa);
    word_count = AW'(wc);
    for (int k = 1; k <= kmax; k++) begin
      e.ctl[4] = (k == 1);
      e.ctl[3] = (k >= 2) && (k <= n + 1);
      e.ctl[2] = (k >= 2 + L) && (k <= n + 1 + L);
      e.ctl[1] = (k == n + 2 + L);
      e.ctl[0] = (k <= n + 2 + L);
      e.addr   = e.ctl[3] ? AW'(sa + k - 2) : AW'(sa + n);
      e.chk_addr = e.ctl[3] || (k >= n + 3 + L);
      e.abt    = 1'b0;
      if (abort_at > 0 && k > abort_at) begin
        e.ctl = 5'b0;
        e.chk_addr = 1'b0;
        e.abt = (k == abort_at + 1);
      end
      sb.push_back(e);
    end
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk50m);
      e = sb.pop_front();
      got = {crc_init, mem_rd_en, crc_en, crc_rdy, busy};
      total++;
      if (got !== e.ctl) begin
        bad++;
        $display("FAIL ctl sa=%0d k=%0d got=%b exp=%b", sa, k, got, e.ctl);
      end
      if (e.chk_addr) begin
        total++;
        if (mem_addr !== e.addr) begin
          bad++;
          $display("FAIL mem_addr sa=%0d k=%0d got=%0d exp=%0d", sa, k, mem_addr, e.addr);
        end
      end
`ifdef CRC_SCAN_ABORT_EN
      total++;
      if (crc_aborted !== e.abt) begin
        bad++;
        $display("FAIL crc_aborted k=%0d got=%b exp=%b", k, crc_aborted, e.abt);
      end
`endif
      crc_start  = (k == poke_a) || (k == poke_b);
      start_addr = crc_start ? AW'(100) : AW'(sa);
      abort      = (k == abort_at);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        total++;
        if ({mem_addr, mem_rd_en, crc_init, crc_en, crc_rdy, busy} !== '0) begin
          bad++;
          $display("FAIL async_rst got addr=%0d ctl=%b exp all zero", mem_addr,
                   {crc_init, mem_rd_en, crc_en, crc_rdy, busy});
        end
        sb.delete();
        repeat (2) @(negedge clk50m);
        rst = 1'b0;
        return;
      end
    end
    crc_start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #5;
    total++;
    if ({mem_addr, mem_rd_en, crc_init, crc_en, crc_rdy, busy} !== '0) begin
      bad++;
      $display("FAIL reset_state got addr=%0d ctl=%b exp all zero", mem_addr,
               {crc_init, mem_rd_en, crc_en, crc_rdy, busy});
    end
    repeat (2) @(negedge clk50m);
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int c0;
    c0 = en_count;
    run_scan(5, 1, 0, 0, 0, 0);
    total++;
    if (en_count - c0 !== 1) begin
      bad++;
      $display("FAIL single_en_count got=%0d exp=1", en_count - c0);
    end
  endtask

  task automatic test_wrap();
    int c0;
    c0 = en_count;
    run_scan(1022, 4, 0, 0, 0, 0);
    total++;
    if (en_count - c0 !== 4) begin
      bad++;
      $display("FAIL wrap_en_count got=%0d exp=4", en_count - c0);
    end
    total++;
    if (mem_addr !== AW'(2)) begin
      bad++;
      $display("FAIL wrap_addr_after got=%0d exp=2", mem_addr);
    end
  endtask

  task automatic test_full_scan();
    int c0;
    c0 = en_count;
    run_scan(0, 0, 0, 0, 0, 0);
    total++;
    if (en_count - c0 !== 1024) begin
      bad++;
      $display("FAIL full_en_count got=%0d exp=1024", en_count - c0);
    end
  endtask

  task automatic test_start_ignored();
    // 8 words: FETCH spans cycles 2..9, DONE is cycle 12.
    run_scan(200, 8, 4, 12, 0, 0);
  endtask

  task automatic test_reset_mid_scan();
    int rdy_seen;
    run_scan(300, 64, 0, 0, 10, 0);
    rdy_seen = 0;
    repeat (80) begin
      @(negedge clk50m);
      if (crc_rdy === 1'b1 || busy === 1'b1) rdy_seen++;
    end
    total++;
    if (rdy_seen !== 0) begin
      bad++;
      $display("FAIL rst_no_rdy got=%0d active cycles exp=0", rdy_seen);
    end
    run_scan(7, 3, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_scan(10, 5, 0, 0, 0, 0);
    run_scan(600, 2, 0, 0, 0, 0);
  endtask

`ifdef CRC_SCAN_ABORT_EN
  task automatic test_abort();
    run_scan(50, 16, 0, 0, 0, 6);
    run_scan(60, 3, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_wrap();
    test_full_scan();
    test_start_ignored();
    test_reset_mid_scan();
    test_back_to_back();
`ifdef CRC_SCAN_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/crc_scan_fsm.md
# crc_scan_fsm

Parametrised address sequencer for CRC generation over a block of memory. On `crc_start` it reads a configurable window of words from a synchronous memory with configurable read latency, qualifies each returned word to the CRC calculator with `crc_en`, and signals completion with `crc_rdy`. It sits between the memory and `crc_calc` and replaces the fixed 1024-word, one-word-per-three-cycles sequencer with a fully pipelined one-word-per-cycle scan.

## Interface
- `ADDR_W`, 10: memory address width; window length is up to 2^ADDR_W words.
- `RD_LAT`, 1: memory read latency in cycles, legal range 1..4.
- `clk50m`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `crc_start`  in  1  start request; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first word address; sampled with `crc_start`.
- `word_count`  in  ADDR_W  number of words; 0 means 2^ADDR_W. Sampled with `crc_start`.
- `mem_addr`  out  ADDR_W  registered read address.
- `mem_rd_en`  out  1  read strobe, one word per cycle.
- `crc_init`  out  1  one-cycle pulse that clears the CRC register before the first word.
- `crc_en`  out  1  memory data valid this cycle; feed to the CRC calculator.
- `crc_rdy`  out  1  one-cycle pulse when the last word has been fed.
- `busy`  out  1  high in every state except IDLE.
- `abort`  in  1  cancel request (only with `CRC_SCAN_ABORT_EN`).
- `crc_aborted`  out  1  one-cycle cancel acknowledge (only with `CRC_SCAN_ABORT_EN`).

## Operation
- States: IDLE, INIT, FETCH, DRAIN, DONE.
- IDLE → INIT when `crc_start` = 1.
  - On that edge, latch `start_addr` into `mem_addr` and latch the remaining count: `word_count`, or 2^ADDR_W if it is 0.
  - The remaining-count register is ADDR_W+1 bits wide.
- INIT (1 cycle): `crc_init` = 1, then go to FETCH.
- FETCH: `mem_rd_en` = 1 every cycle.
  - Each edge: `mem_addr` += 1, wrapping modulo 2^ADDR_W (for example 1023 → 0 at ADDR_W = 10), and remaining −= 1.
  - When remaining = 1 in a FETCH cycle, that is the last read; go to DRAIN.
- DRAIN: lasts exactly RD_LAT cycles, with `mem_rd_en` = 0, then go to DONE.
- DONE (1 cycle): `crc_rdy` = 1, then go to IDLE.
- `crc_en` is `mem_rd_en` delayed by an RD_LAT-stage shift register, so it asserts exactly once per word read.
- `crc_start` outside IDLE, including in DONE, is ignored; it is not queued.
- After completion, `mem_addr` holds the last read address + 1 (mod 2^ADDR_W) until the next start.
- Reset (`rst` = 1 at any time, including mid-scan):
  - state → IDLE, shift register cleared;
  - `mem_addr` = 0, `mem_rd_en` = `crc_init` = `crc_en` = `crc_rdy` = `busy` = 0, `crc_aborted` = 0;
  - no `crc_rdy` is produced for the interrupted scan.
- Outputs are decoded from registered state and the registered shift register; there are no combinational paths from inputs to outputs.

## Timing
- Cycle 0 is the edge that samples `crc_start` = 1; N is the effective word count.
- Cycle 1: INIT, `crc_init` = 1, `busy` = 1.
- Cycles 2..N+1: `mem_rd_en` = 1, with `mem_addr` = start_addr + k − 2 in cycle k.
- Cycles 2+RD_LAT..N+1+RD_LAT: `crc_en` = 1.
- Cycle N+2+RD_LAT: DONE, `crc_rdy` = 1, `busy` = 1.
- Cycle N+3+RD_LAT: IDLE, `busy` = 0; a new `crc_start` is accepted at the following edge.
- Throughput: 1 word per cycle. Total latency from start to `crc_rdy` is N+2+RD_LAT cycles.

## Configuration
- `CRC_SCAN_ABORT_EN` defined:
  - The `abort` and `crc_aborted` ports exist.
  - `abort` = 1 sampled in INIT, FETCH or DRAIN sends the next state to IDLE and clears the shift register.
  - On the following cycle, `mem_rd_en` = `crc_en` = 0, `crc_aborted` = 1 for one cycle, and `crc_rdy` is never asserted.
  - `abort` in IDLE or DONE is ignored; DONE completes normally.
  - If `abort` and `crc_start` are both high in IDLE, the start wins.
- `CRC_SCAN_ABORT_EN` undefined: neither port exists and every scan runs to DONE.

## Test plan
All scenarios use ADDR_W = 10, RD_LAT = 2.
- Full scan: `crc_start`, `start_addr` = 0, `word_count` = 0 → 1024 `mem_rd_en` cycles at addresses 0..1023, then 1024 `crc_en` cycles, then `crc_rdy` 1028 cycles after the start edge.
- Wrap-around: `start_addr` = 1022, `word_count` = 4 → addresses 1022, 1023, 0, 1 on consecutive cycles; 4 `crc_en` pulses; `crc_rdy` at cycle 8; `mem_addr` = 2 afterwards.
- Single word: `start_addr` = 5, `word_count` = 1 → `crc_init` at cycle 1, one read at address 5 in cycle 2, `crc_en` at cycle 4, `crc_rdy` at cycle 5, `busy` low at cycle 6.
- Start ignored: pulse `crc_start` with `start_addr` = 100 during FETCH and again during DONE → no effect on the running scan; the next accepted start must occur in IDLE.
- Reset mid-scan: assert `rst` in cycle 10 of a 64-word scan → all outputs 0 asynchronously, no `crc_rdy`; a fresh start then completes normally.
- Abort (macro defined): `abort` in cycle 6 of a 16-word scan → `mem_rd_en` and `crc_en` low from cycle 7, `crc_aborted` pulses in cycle 7, no `crc_rdy`, `busy` = 0 in cycle 7.
